// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state type for the data-memory access unit
// Contents:
//   MEM_BYTES, ADDR_W         RAM geometry
//   SIZE_*                    access size encodings
//   ERR_*                     response error codes
//   state_t                   sequencer states
package mem_pkg;

  localparam int MEM_BYTES = 512;
  localparam int ADDR_W    = 9;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_check.sv
// rtl/mem_access_check.sv - combinational legality check of one memory request
// Ports:
//   addr  in  32  byte address
//   size  in  2   access size code
//   load  in  1   load requested
//   store in  1   store requested
//   err   out 2   ERR_* code; illegal beats misaligned beats range
module mem_access_check
  import mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        load,
  input  logic        store,
  output logic [1:0]  err
);

  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W + 1)'(MEM_BYTES - 1);

  logic [1:0]      span;
  logic [ADDR_W:0] last;

  // Extra top bit on last so an access running past the end is not lost to wrap.
  assign last = {1'b0, addr[ADDR_W-1:0]} + {{(ADDR_W - 1){1'b0}}, span};

  always_comb begin
    span = 2'd0;
    case (size)
      SIZE_HALF: span = 2'd1;
      SIZE_WORD: span = 2'd3;
      default:   span = 2'd0;
    endcase
  end

  always_comb begin
    err = ERR_NONE;
    if (size == SIZE_ILL || (load && store)) begin
      err = ERR_ILLEGAL;
    end else if ((size == SIZE_HALF && addr[0]) ||
                 (size == SIZE_WORD && addr[1:0] != 2'b00)) begin
      err = ERR_MISALIGN;
    end else if (addr[31:ADDR_W] != '0 || last > LAST_BYTE) begin
      err = ERR_RANGE;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between EX/MEM and the data RAM
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_load, req_store, req_size,
//   req_se, req_addr, req_wdata,
//   req_rd                            request fields
//   ram_a, ram_di, ram_size, ram_rw,
//   ram_e, ram_se                     async RAM port, active one cycle per legal access
//   ram_do                            combinational RAM read data
//   resp_valid/resp_ready             response handshake to writeback
//   resp_we, resp_rd, resp_data,
//   resp_err, resp_addr               response fields
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_di,
  output logic [1:0]        ram_size,
  output logic              ram_rw,
  output logic              ram_e,
  output logic              ram_se,
  input  logic [31:0]       ram_do,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_err,
  output logic [31:0]       resp_addr
);

  state_t      state, state_n;
  logic        ld_q, st_q, se_q;
  logic [1:0]  size_q, err_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [4:0]  rd_q;
  logic [1:0]  chk_err;
  logic        accept, has_op;

  // Checked on the incoming fields so the verdict is registered together with them;
  // this lets an error response appear the cycle right after accept.
  mem_access_check u_check (
    .addr  (req_addr),
    .size  (req_size),
    .load  (req_load),
    .store (req_store),
    .err   (chk_err)
  );

  assign req_ready = !reset && (state == IDLE || (state == RESP && resp_ready));
  assign accept    = req_valid && req_ready;
  assign has_op    = req_load || req_store;

  always_comb begin
    state_n    = state;
    ram_e      = 1'b0;
    ram_rw     = 1'b0;
    ram_a      = '0;
    ram_di     = '0;
    ram_size   = '0;
    ram_se     = 1'b0;
    resp_valid = 1'b0;
    resp_we    = 1'b0;
    resp_rd    = '0;
    resp_data  = '0;
    resp_err   = '0;
    resp_addr  = '0;

    case (state)
      IDLE: begin
        if (accept && has_op) state_n = (chk_err == ERR_NONE) ? ACCESS : RESP;
      end
      ACCESS: begin
        state_n = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          if (accept && has_op) state_n = (chk_err == ERR_NONE) ? ACCESS : RESP;
          else                  state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are gated by reset directly so ram_e drops in the reset cycle itself.
    if (!reset) begin
      if (state == ACCESS) begin
        ram_e    = 1'b1;
        ram_rw   = st_q;
        ram_a    = addr_q[ADDR_W-1:0];
        ram_di   = wdata_q;
        ram_size = size_q;
        ram_se   = se_q;
      end
      if (state == RESP) begin
        resp_valid = 1'b1;
        resp_we    = ld_q && (err_q == ERR_NONE);
        resp_rd    = rd_q;
        resp_data  = data_q;
        resp_err   = err_q;
        resp_addr  = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_n;
      if (accept && has_op) begin
        ld_q    <= req_load;
        st_q    <= req_store;
        se_q    <= req_se;
        size_q  <= req_size;
        err_q   <= chk_err;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        data_q  <= '0;
      end else if (state == ACCESS && ld_q) begin
        data_q <= ram_do;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store, req_se;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [8:0]  ram_a;
  logic [31:0] ram_di, ram_do;
  logic [1:0]  ram_size;
  logic        ram_rw, ram_e, ram_se;
  logic        resp_valid, resp_ready, resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, resp_addr;
  logic [1:0]  resp_err;

  int checks = 0;
  int errors = 0;
  int e_count = 0;
  int consec = 0;
  logic prev_e = 1'b0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_size(req_size), .req_se(req_se),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .ram_a(ram_a), .ram_di(ram_di), .ram_size(ram_size), .ram_rw(ram_rw),
    .ram_e(ram_e), .ram_se(ram_se), .ram_do(ram_do),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err),
    .resp_addr(resp_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Little-endian async RAM: combinational read, write at the clock edge.
  logic [7:0] mem [0:511];
  logic [7:0] b0, b1, b2, b3;

  always @(posedge clk) begin
    if (ram_e && ram_rw) begin
      mem[ram_a] <= ram_di[7:0];
      if (ram_size != 2'b00) mem[ram_a + 9'd1] <= ram_di[15:8];
      if (ram_size == 2'b10) begin
        mem[ram_a + 9'd2] <= ram_di[23:16];
        mem[ram_a + 9'd3] <= ram_di[31:24];
      end
    end
    if (ram_e) e_count = e_count + 1;
    if (ram_e && prev_e) consec = consec + 1;
    prev_e = ram_e;
  end

  always_comb begin
    b0 = mem[ram_a];
    b1 = mem[ram_a + 9'd1];
    b2 = mem[ram_a + 9'd2];
    b3 = mem[ram_a + 9'd3];
    case (ram_size)
      2'b00:   ram_do = ram_se ? {{24{b0[7]}}, b0} : {24'b0, b0};
      2'b01:   ram_do = ram_se ? {{16{b1[7]}}, b1, b0} : {16'b0, b1, b0};
      default: ram_do = {b3, b2, b1, b0};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] any_out();
    return 32'(|{resp_valid, resp_we, resp_data, resp_err, resp_rd, resp_addr,
                 ram_e, ram_rw, ram_a, ram_di, ram_size, ram_se});
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic se,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1;
    req_load  = ld;
    req_store = st;
    req_size  = sz;
    req_se    = se;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
  endtask

  // Starts anywhere before a rising edge in IDLE with resp_ready=1; ends at edge+1.
  task automatic do_req(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                        input logic se, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [1:0] eerr, input logic [31:0] edata);
    int e0;
    drive(ld, st, sz, se, addr, wd, rd);
    #1 chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    e0 = e_count;
    @(posedge clk);
    #1 idle_req();
    #1;
    if (eerr == ERR_NONE) begin
      chk({tag, "_access_ram_e"}, 32'(ram_e), 32'd1);
      chk({tag, "_access_ram_a"}, 32'(ram_a), 32'(addr[8:0]));
      chk({tag, "_access_ram_rw"}, 32'(ram_rw), 32'(st));
      chk({tag, "_access_resp_valid"}, 32'(resp_valid), 32'd0);
      @(posedge clk);
      #2;
    end
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'(eerr));
    chk({tag, "_resp_we"}, 32'(resp_we), 32'(ld && eerr == ERR_NONE));
    chk({tag, "_resp_data"}, resp_data, edata);
    chk({tag, "_resp_rd"}, 32'(resp_rd), 32'(rd));
    chk({tag, "_resp_addr"}, resp_addr, addr);
    chk({tag, "_resp_ram_e"}, 32'(ram_e), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ram_e_count"}, 32'(e_count - e0), (eerr == ERR_NONE) ? 32'd1 : 32'd0);
    chk({tag, "_back_idle"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    resp_ready = 1'b1;
    req_size = 2'b00;
    req_se = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_rd = '0;
    idle_req();

    // Reset: no handshake, every output quiet even with a request present.
    repeat (2) @(posedge clk);
    #1 drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd1);
    #1 chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_outs_zero", any_out(), 32'd0);
    @(posedge clk);
    #1 idle_req();
    reset = 1'b0;
    #1 chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_outs_zero", any_out(), 32'd0);

    // Word store then load back.
    do_req("st_w", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, ERR_NONE, 32'h0);
    do_req("ld_w", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd5, ERR_NONE, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads.
    do_req("st_b", 1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h00000080, 5'd2, ERR_NONE, 32'h0);
    do_req("ld_bs", 1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h21, 32'h0, 5'd6, ERR_NONE, 32'hFFFFFF80);
    do_req("ld_bu", 1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h21, 32'h0, 5'd7, ERR_NONE, 32'h00000080);

    // Last halfword of the RAM is legal.
    do_req("st_h_top", 1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h1FE, 32'h0000BEEF, 5'd3, ERR_NONE, 32'h0);
    do_req("ld_h_top", 1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h1FE, 32'h0, 5'd8, ERR_NONE, 32'hFFFFBEEF);
    do_req("ld_b_top", 1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h1FF, 32'h0, 5'd9, ERR_NONE, 32'h000000BE);

    // Error cases and priority.
    do_req("ld_h_mis", 1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h13, 32'h0, 5'd10, ERR_MISALIGN, 32'h0);
    do_req("ld_w_1fe", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1FE, 32'h0, 5'd11, ERR_MISALIGN, 32'h0);
    do_req("ld_b_200", 1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h200, 32'h0, 5'd12, ERR_RANGE, 32'h0);
    do_req("ld_w_hi", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 5'd13, ERR_RANGE, 32'h0);
    do_req("st_mis_hi", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h203, 32'h1, 5'd14, ERR_MISALIGN, 32'h0);
    do_req("ld_sz11", 1'b1, 1'b0, SIZE_ILL, 1'b0, 32'h10, 32'h0, 5'd15, ERR_ILLEGAL, 32'h0);
    do_req("ldst_w", 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd16, ERR_ILLEGAL, 32'h0);
    do_req("ldst_sz11", 1'b1, 1'b1, SIZE_ILL, 1'b0, 32'h13, 32'h0, 5'd17, ERR_ILLEGAL, 32'h0);

    // Handshake with neither load nor store is swallowed.
    drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd18);
    #1 chk("noop_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 idle_req();
    #1 chk("noop_no_resp", 32'(resp_valid), 32'd0);
    chk("noop_no_ram_e", 32'(ram_e), 32'd0);
    chk("noop_still_idle", 32'(req_ready), 32'd1);

    // Stalled response with a queued load.
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 5'd7);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h21, 32'h0, 5'd9);
    #1 chk("stall_access_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2 chk("stall_resp_valid", 32'(resp_valid), 32'd1);
    chk("stall_resp_data", resp_data, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 chk("stall_hold_valid", 32'(resp_valid), 32'd1);
      chk("stall_hold_data", resp_data, 32'hDEADBEEF);
      chk("stall_hold_rd", 32'(resp_rd), 32'd7);
      chk("stall_hold_we", 32'(resp_we), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1 chk("release_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 idle_req();
    #1 chk("queued_access_ram_e", 32'(ram_e), 32'd1);
    chk("queued_access_ram_a", 32'(ram_a), 32'h21);
    chk("queued_access_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #2 chk("queued_resp_data", resp_data, 32'h00000080);
    chk("queued_resp_rd", 32'(resp_rd), 32'd9);
    @(posedge clk);
    #1;

    // Back-to-back: load accepted in the store's response cycle sees the new data.
    drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'hCAFEF00D, 5'd0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 5'd3);
    #1 chk("b2b_access_ready", 32'(req_ready), 32'd0);
    chk("b2b_st_ram_e", 32'(ram_e), 32'd1);
    @(posedge clk);
    #2 chk("b2b_st_resp", 32'(resp_valid), 32'd1);
    chk("b2b_st_we", 32'(resp_we), 32'd0);
    chk("b2b_resp_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 idle_req();
    #1 chk("b2b_ld_ram_e", 32'(ram_e), 32'd1);
    chk("b2b_ld_ram_a", 32'(ram_a), 32'h40);
    chk("b2b_ld_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #2 chk("b2b_ld_data", resp_data, 32'hCAFEF00D);
    chk("b2b_ld_we", 32'(resp_we), 32'd1);
    chk("b2b_ld_rd", 32'(resp_rd), 32'd3);
    @(posedge clk);
    #1;

    // Reset during a store's ACCESS cycle.
    drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h80, 32'h11111111, 5'd4);
    @(posedge clk);
    #1 idle_req();
    reset = 1'b1;
    #1 chk("rst_access_outs_zero", any_out(), 32'd0);
    chk("rst_access_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rst_after_idle", 32'(req_ready), 32'd1);
    chk("rst_after_outs_zero", any_out(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end

    chk("ram_e_never_consecutive", 32'(consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
